// File: rtl/step_tracker_if.sv
// Phase-bus connection between the ring-sequencer side and the step tracker.
// The master drives phase and control inputs; the slave returns the tracked position and status.
interface step_tracker_if #(
  parameter int POS_W = 8
) ();
  logic [3:0]       Phase;
  logic             Home;
  logic             Clear;
  logic [POS_W-1:0] Pos;
  logic             Dir;
  logic             StepPulse;
  logic             Locked;
  logic             Err;

  modport master (
    output Phase, Home, Clear,
    input  Pos, Dir, StepPulse, Locked, Err
  );

  modport slave (
    input  Phase, Home, Clear,
    output Pos, Dir, StepPulse, Locked, Err
  );
endinterface

// File: rtl/step_tracker.sv
// Decodes one-hot phase changes into forward/backward steps on a wrapping position count,
// and latches illegal phase sequences as a fault until it is cleared.
module step_tracker #(
  parameter int POS_W = 8
) (
  input logic          CLK,
  input logic          reset,
  step_tracker_if.slave bus
);

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    LOCKED   = 2'd1,
    FAULT    = 2'd2
  } state_t;

  state_t           state, state_next;
  logic [3:0]       prev, prev_next;
  logic [POS_W-1:0] pos, pos_next;
  logic             dir, dir_next;
  logic             pulse, pulse_next;
  logic             locked, err;

  logic       valid;
  logic [3:0] fwd_succ;
  logic [3:0] bwd_succ;

  assign valid    = $onehot(bus.Phase);
  assign fwd_succ = {prev[2:0], prev[3]};
  assign bwd_succ = {prev[0], prev[3:1]};

  always_comb begin
    // NOTE: every value is defaulted before the case so no path leaves one unassigned and infers a latch.
    state_next = state;
    prev_next  = prev;
    pos_next   = pos;
    dir_next   = dir;
    pulse_next = 1'b0;

    unique case (state)
      UNLOCKED: begin
        if (valid) begin
          prev_next  = bus.Phase;
          state_next = LOCKED;
        end
      end

      LOCKED: begin
        // prev is always one-hot here, so matching a successor implies a legal code
        if (bus.Phase == prev) begin
          state_next = LOCKED;
        end else if (bus.Phase == fwd_succ) begin
          pos_next   = pos + 1'b1;
          dir_next   = 1'b1;
          pulse_next = 1'b1;
          prev_next  = bus.Phase;
        end else if (bus.Phase == bwd_succ) begin
          pos_next   = pos - 1'b1;
          dir_next   = 1'b0;
          pulse_next = 1'b1;
          prev_next  = bus.Phase;
        end else begin
          state_next = FAULT;
        end
      end

      FAULT: begin
        if (bus.Clear) begin
          if (valid) begin
            prev_next  = bus.Phase;
            state_next = LOCKED;
          end else begin
            state_next = UNLOCKED;
          end
        end
      end

      default: state_next = UNLOCKED;
    endcase

    // Home wins over any step, in every state
    if (bus.Home) pos_next = '0;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge CLK) begin
    if (reset) begin
      state  <= UNLOCKED;
      prev   <= 4'b0001;
      pos    <= '0;
      dir    <= 1'b0;
      pulse  <= 1'b0;
      locked <= 1'b0;
      err    <= 1'b0;
    end else begin
      state  <= state_next;
      prev   <= prev_next;
      pos    <= pos_next;
      dir    <= dir_next;
      pulse  <= pulse_next;
      locked <= (state_next == LOCKED);
      err    <= (state_next == FAULT);
    end
  end

  assign bus.Pos       = pos;
  assign bus.Dir       = dir;
  assign bus.StepPulse = pulse;
  assign bus.Locked    = locked;
  assign bus.Err       = err;

endmodule

// File: tb/tb_step_tracker.sv
// Self-checking bench for step_tracker: directed scenarios followed by a random phase stream,
// every cycle compared against a phase-index reference model.
module tb_step_tracker;

  localparam int POS_W = 8;
  localparam int MODV  = 1 << POS_W;

  logic CLK = 1'b0;
  logic reset;

  step_tracker_if #(.POS_W(POS_W)) bus ();

  step_tracker #(.POS_W(POS_W)) dut (
    .CLK   (CLK),
    .reset (reset),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // Reference model: phase as a ring index 0..3, mode as plain flags
  int m_pos;
  int m_prev_idx;
  bit m_locked;
  bit m_err;
  bit m_dir;
  bit m_pulse;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int idx_of(input logic [3:0] p);
    if ($countones(p) != 1) return -1;
    for (int i = 0; i < 4; i++) if (p[i]) return i;
    return -1;
  endfunction

  task automatic model_update(input bit rst, input logic [3:0] ph, input bit home, input bit clr);
    int  k;
    int  d;
    bit  was_locked;
    bit  was_err;
    if (rst) begin
      m_locked = 0; m_err = 0; m_prev_idx = 0;
      m_pos = 0; m_dir = 0; m_pulse = 0;
      return;
    end
    k          = idx_of(ph);
    was_locked = m_locked;
    was_err    = m_err;
    m_pulse    = 0;
    if (!was_locked && !was_err) begin
      if (k >= 0) begin
        m_prev_idx = k;
        m_locked   = 1;
      end
    end else if (was_locked) begin
      if (k < 0) begin
        m_locked = 0; m_err = 1;
      end else begin
        d = (k - m_prev_idx + 4) % 4;
        case (d)
          1: begin m_pos = (m_pos + 1) % MODV; m_dir = 1; m_pulse = 1; m_prev_idx = k; end
          3: begin m_pos = (m_pos + MODV - 1) % MODV; m_dir = 0; m_pulse = 1; m_prev_idx = k; end
          2: begin m_locked = 0; m_err = 1; end
          default: ;
        endcase
      end
    end else if (clr) begin
      m_err = 0;
      if (k >= 0) begin
        m_prev_idx = k;
        m_locked   = 1;
      end
    end
    if (home) m_pos = 0;
  endtask

  task automatic cycle(input bit rst, input logic [3:0] ph, input bit home, input bit clr);
    @(negedge CLK);
    reset     = rst;
    bus.Phase = ph;
    bus.Home  = home;
    bus.Clear = clr;
    model_update(rst, ph, home, clr);
    @(posedge CLK);
    #1;
    check("pos",    32'(bus.Pos),       32'(m_pos));
    check("dir",    32'(bus.Dir),       32'(m_dir));
    check("pulse",  32'(bus.StepPulse), 32'(m_pulse));
    check("locked", 32'(bus.Locked),    32'(m_locked));
    check("err",    32'(bus.Err),       32'(m_err));
    check("excl",   32'(bus.Locked & bus.Err), 32'd0);
  endtask

  task automatic go(input logic [3:0] ph, input bit home = 0, input bit clr = 0);
    cycle(1'b0, ph, home, clr);
  endtask

  logic [3:0] cur;
  logic [3:0] nxt;
  int         r;
  bit         rh, rc, rr;

  initial begin
    reset     = 1'b1;
    bus.Phase = 4'b0001;
    bus.Home  = 1'b0;
    bus.Clear = 1'b0;
    m_pos = 0; m_prev_idx = 0; m_locked = 0; m_err = 0; m_dir = 0; m_pulse = 0;

    // Reset and lock
    cycle(1'b1, 4'b0001, 0, 0);
    cycle(1'b1, 4'b0001, 0, 0);
    go(4'b0001);
    check("lock_locked", 32'(bus.Locked), 32'd1);
    check("lock_pos",    32'(bus.Pos),    32'd0);

    // Forward run
    go(4'b0010); check("fwd_pulse1", 32'(bus.StepPulse), 32'd1);
    go(4'b0100);
    go(4'b1000);
    go(4'b0001);
    check("fwd_pos4", 32'(bus.Pos), 32'd4);
    check("fwd_dir",  32'(bus.Dir), 32'd1);
    go(4'b0001); check("fwd_pulse_fall", 32'(bus.StepPulse), 32'd0);

    // Backward and wrap
    go(4'b0001, 1);
    go(4'b1000);
    check("wrap_ff",  32'(bus.Pos), 32'hff);
    check("wrap_dir", 32'(bus.Dir), 32'd0);
    go(4'b0001);
    check("wrap_00",  32'(bus.Pos), 32'h00);

    // Reach Pos=5 locked on 0001
    go(4'b0010); go(4'b0100); go(4'b1000);
    go(4'b1000, 1);
    go(4'b0001); go(4'b0010); go(4'b0100); go(4'b1000); go(4'b0001);
    check("pre_skip_pos", 32'(bus.Pos), 32'd5);

    // Skip fault
    go(4'b0100);
    check("skip_err",    32'(bus.Err),       32'd1);
    check("skip_locked", 32'(bus.Locked),    32'd0);
    check("skip_pos",    32'(bus.Pos),       32'd5);
    check("skip_pulse",  32'(bus.StepPulse), 32'd0);
    go(4'b0010, 0, 0);
    check("fault_hold_pos", 32'(bus.Pos), 32'd5);

    // Fault recovery
    go(4'b0000, 0, 1);
    check("rec_err",    32'(bus.Err),    32'd0);
    check("rec_locked", 32'(bus.Locked), 32'd0);
    go(4'b0100);
    check("rec_relock", 32'(bus.Locked), 32'd1);
    check("rec_pos",    32'(bus.Pos),    32'd5);

    // Home collision
    go(4'b1000); go(4'b0001);
    check("pre_home_pos", 32'(bus.Pos), 32'd7);
    go(4'b0010, 1);
    check("home_pos",   32'(bus.Pos),       32'd0);
    check("home_dir",   32'(bus.Dir),       32'd1);
    check("home_pulse", 32'(bus.StepPulse), 32'd1);
    cycle(1'b1, 4'b0100, 0, 0);
    check("rst_locked", 32'(bus.Locked),    32'd0);
    check("rst_pulse",  32'(bus.StepPulse), 32'd0);

    // Random stream, biased toward legal neighbours
    cur = 4'b0100;
    for (int n = 0; n < 3000; n++) begin
      r = $urandom_range(0, 99);
      if (r < 35)      nxt = {cur[2:0], cur[3]};
      else if (r < 65) nxt = {cur[0], cur[3:1]};
      else if (r < 78) nxt = cur;
      else if (r < 85) nxt = {cur[1:0], cur[3:2]};
      else if (r < 92) nxt = 4'($urandom_range(0, 15));
      else             nxt = 4'b0001 << $urandom_range(0, 3);
      if ($countones(nxt) == 1) cur = nxt;
      rh = ($urandom_range(0, 99) < 5);
      rc = ($urandom_range(0, 99) < 20);
      rr = ($urandom_range(0, 99) < 2);
      cycle(rr, nxt, rh, rc);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
